sd_block_sched: RTL

Round-robin scheduler that shares the single HPS SD block channel among up to three virtual-drive requesters (D1, D2, cartridge/D5). It sits between the ZPU-side drive logic and the `hps_io` `sd_lba`/`sd_rd`/`sd_wr`/`sd_ack` ports. It owns the LBA register and per-drive strobes, sequences one 512-byte transfer at a time and reports completion or timeout per requester.

---
 rtl/sd_block_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sd_block_sched.sv
// sd_block_sched: round-robin arbiter that shares the single HPS SD block
// channel among NREQ virtual-drive requesters. It owns the LBA register and
// the per-drive read/write strobes, runs one 512-byte transfer at a time,
// and returns a DONE pulse (plus ERR on ack timeout) to the granted requester.
module sd_block_sched #(
  parameter int          NREQ    = 3,
  parameter int unsigned TIMEOUT = 5000000
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NREQ-1:0]    REQ_RD,
  input  logic [NREQ-1:0]    REQ_WR,
  input  logic [32*NREQ-1:0] REQ_LBA,
  output logic [NREQ-1:0]    REQ_DONE,
  output logic [NREQ-1:0]    REQ_ERR,
  output logic               BUSY,
  output logic [1:0]         CUR_ID,
  output logic [31:0]        SD_LBA,
  output logic [NREQ-1:0]    SD_RD,
  output logic [NREQ-1:0]    SD_WR,
  input  logic [NREQ-1:0]    SD_ACK
);

  // Counter only needs to reach TIMEOUT-1, so it can never wrap.
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_XFER,
    S_DONE,
    S_GAP
  } state_t;

  state_t          state;
  logic [1:0]      last_id;   // most recently granted requester
  logic [CW-1:0]   tmo_cnt;   // cycles spent waiting for the ack to rise
  logic            err_flag;  // current transfer ended by timeout

  logic [NREQ-1:0] pending;
  logic            pick_valid;
  logic [1:0]      pick_id;
  logic [1:0]      cand;
  logic            ack_cur;

  // One-hot mask selecting a single requester.
  function automatic logic [NREQ-1:0] id_mask(input logic [1:0] id);
    id_mask     = '0;
    id_mask[id] = 1'b1;
  endfunction

  assign pending = REQ_RD | REQ_WR;
  // Only the ack lane of the granted requester is ever looked at.
  assign ack_cur = SD_ACK[CUR_ID];

  // Round-robin search: first pending requester starting after last_id.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    // Walk from the farthest candidate back to the nearest so the nearest
    // pending one (highest round-robin priority) is the last to overwrite.
    for (int k = NREQ; k >= 1; k--) begin
      cand = 2'((int'(last_id) + k) % NREQ);
      if (pending[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Scheduler FSM with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous and clears every register, outputs included,
    // so a reset mid-transfer drops the strobe on the very next edge.
    if (!RESET_N) begin
      state    <= S_IDLE;
      last_id  <= 2'(NREQ - 1);
      tmo_cnt  <= '0;
      err_flag <= 1'b0;
      REQ_DONE <= '0;
      REQ_ERR  <= '0;
      BUSY     <= 1'b0;
      CUR_ID   <= '0;
      SD_LBA   <= '0;
      SD_RD    <= '0;
      SD_WR    <= '0;
    end else begin
      // Completion flags are single-cycle pulses.
      REQ_DONE <= '0;
      REQ_ERR  <= '0;

      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            CUR_ID   <= pick_id;
            SD_LBA   <= REQ_LBA[{pick_id, 5'b00000} +: 32];
            // Read wins when a requester asserts both levels.
            if (REQ_RD[pick_id]) SD_RD <= id_mask(pick_id);
            else                 SD_WR <= id_mask(pick_id);
            BUSY     <= 1'b1;
            last_id  <= pick_id;
            tmo_cnt  <= '0;
            err_flag <= 1'b0;
            state    <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          if (ack_cur) begin
            SD_RD <= '0;
            SD_WR <= '0;
            state <= S_XFER;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            // Strobe has been up for TIMEOUT cycles with no answer.
            SD_RD    <= '0;
            SD_WR    <= '0;
            err_flag <= 1'b1;
            state    <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_XFER: begin
          // The host side holds ack for the whole block; no timeout here.
          if (!ack_cur) state <= S_DONE;
        end

        S_DONE: begin
          REQ_DONE <= id_mask(CUR_ID);
          REQ_ERR  <= err_flag ? id_mask(CUR_ID) : '0;
          state    <= S_GAP;
        end

        S_GAP: begin
          // Requests are ignored here so the requester can drop its level.
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
